// File: rtl/road_pkg.sv
// Shared road/object definitions for the enemy spawn path.
//   LANE_W / TYPE_W / SPEED_W : field widths of a spawn request
//   GAP_W                     : width of the inter-spawn frame counter
//   MIN_GAP_DEFAULT           : default minimum frames between spawns
//   car_t                     : enemy car type codes
//   spawn_state_t             : spawner FSM states
package road_pkg;

  localparam int LANE_W          = 2;
  localparam int TYPE_W          = 2;
  localparam int SPEED_W         = 3;
  localparam int GAP_W           = 5;
  localparam int MIN_GAP_DEFAULT = 16;

  typedef enum logic [TYPE_W-1:0] {
    CAR_SLOW   = 2'd0,
    CAR_NORMAL = 2'd1,
    CAR_TRUCK  = 2'd2,
    CAR_RACER  = 2'd3
  } car_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GAP = 2'd1,
    ST_ROLL     = 2'd2,
    ST_OFFER    = 2'd3
  } spawn_state_t;

endpackage

// File: rtl/spawn_gap_timer.sv
// Frame-based gap counter between enemy spawns.
//   clock, reset : system clock, async active-low reset
//   load         : load gap counter with load_value (wins over frame_tick)
//   load_value   : gap length in frames
//   frame_tick   : decrement strobe (already qualified by the caller)
//   expired      : one-cycle pulse on the tick that takes the count 1 -> 0
module spawn_gap_timer
  import road_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [GAP_W-1:0] load_value,
  input  logic             frame_tick,
  output logic             expired
);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (load) begin
      gap_cnt <= load_value;
    end else if (frame_tick && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign expired = frame_tick && !load && (gap_cnt == GAP_W'(1));

endmodule

// File: rtl/enemy_spawner.sv
// Enemy car spawner: waits a random frame gap, rolls lane/type/speed from
// the LFSR word and offers the spawn over valid/ready, capping the number
// of enemies on screen.
//   clock, reset  : system clock, async active-low reset
//   enable        : game running; low returns to IDLE and withdraws offers
//   frame_tick    : one-cycle pulse per video frame
//   rnd           : random word from the LFSR
//   despawn       : pulse when an enemy leaves the screen or is destroyed
//   spawn_ready   : object manager can accept a spawn
//   spawn_valid   : spawn request pending
//   spawn_lane    : lane index 0..3
//   spawn_type    : car type code
//   spawn_speed   : speed 1..4
//   active_count  : enemies currently on screen
module enemy_spawner
  import road_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_LANES     = 4,
  parameter int MIN_GAP       = MIN_GAP_DEFAULT,
  parameter int MAX_ACTIVE    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [DATAWIDTH_BUS-1:0] rnd,
  input  logic                     despawn,
  input  logic                     spawn_ready,
  output logic                     spawn_valid,
  output logic [LANE_W-1:0]        spawn_lane,
  output logic [TYPE_W-1:0]        spawn_type,
  output logic [SPEED_W-1:0]       spawn_speed,
  output logic [1:0]               active_count
);

  spawn_state_t      state;
  logic [LANE_W-1:0] last_lane;
  logic [LANE_W-1:0] lane_q;
  car_t              type_q;
  logic [SPEED_W-1:0] speed_q;

  logic              accept;
  logic              roll_go;
  logic              gap_load;
  logic              gap_tick;
  logic              gap_expired;
  logic [GAP_W-1:0]  gap_value;
  logic [LANE_W-1:0] lane_roll;
  logic [LANE_W-1:0] lane_pick;

  // enable gates the handshake so a withdrawn offer can never be counted
  assign accept   = enable && (state == ST_OFFER) && spawn_ready;
  assign roll_go  = enable && (state == ST_ROLL) &&
                    (active_count != 2'(MAX_ACTIVE));
  assign gap_load = enable && ((state == ST_IDLE) || accept);
  assign gap_tick = frame_tick && (state == ST_WAIT_GAP);

  assign gap_value = GAP_W'(MIN_GAP) + GAP_W'(rnd[3:0]);

  // never spawn twice in a row in the same lane
  assign lane_roll = rnd[1:0];
  assign lane_pick = (lane_roll == last_lane)
                   ? LANE_W'((32'(last_lane) + 32'd1) % NUM_LANES)
                   : lane_roll;

  spawn_gap_timer u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_load),
    .load_value (gap_value),
    .frame_tick (gap_tick),
    .expired    (gap_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (!enable) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     state <= ST_WAIT_GAP;
        ST_WAIT_GAP: if (gap_expired) state <= ST_ROLL;
        ST_ROLL:     if (roll_go)     state <= ST_OFFER;
        ST_OFFER:    if (accept)      state <= ST_WAIT_GAP;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q  <= '0;
      type_q  <= CAR_SLOW;
      speed_q <= '0;
    end else if (roll_go) begin
      lane_q  <= lane_pick;
      type_q  <= car_t'(rnd[7:6]);
      speed_q <= SPEED_W'(1) + SPEED_W'(rnd[5:4]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lane <= '0;
    end else if (accept) begin
      last_lane <= lane_q;
    end
  end

  // accept and despawn together cancel; despawn alone saturates at 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_count <= '0;
    end else if (accept && !despawn) begin
      if (active_count != 2'(MAX_ACTIVE)) active_count <= active_count + 2'd1;
    end else if (!accept && despawn) begin
      if (active_count != '0) active_count <= active_count - 2'd1;
    end
  end

  assign spawn_valid = (state == ST_OFFER);
  assign spawn_lane  = lane_q;
  assign spawn_type  = type_q;
  assign spawn_speed = speed_q;

endmodule

// File: tb/tb_enemy_spawner.sv
module tb_enemy_spawner;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       frame_tick;
  logic [7:0] rnd;
  logic       despawn;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic [1:0] spawn_type;
  logic [2:0] spawn_speed;
  logic [1:0] active_count;

  int total = 0;
  int bad   = 0;

  enemy_spawner #(
    .DATAWIDTH_BUS (8),
    .NUM_LANES     (4),
    .MIN_GAP       (16),
    .MAX_ACTIVE    (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .frame_tick   (frame_tick),
    .rnd          (rnd),
    .despawn      (despawn),
    .spawn_ready  (spawn_ready),
    .spawn_valid  (spawn_valid),
    .spawn_lane   (spawn_lane),
    .spawn_type   (spawn_type),
    .spawn_speed  (spawn_speed),
    .active_count (active_count)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  // Drive a full gap of `gap` ticks; roll_rnd is presented during the ROLL cycle.
  task automatic expire_gap(input int gap, input logic [7:0] roll_rnd, input string tag);
    run_ticks(gap - 1);
    chk_eq({tag, "_pre"}, spawn_valid, 0);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    rnd = roll_rnd;
    chk_eq({tag, "_roll"}, spawn_valid, 0);
    cyc();
    chk_eq({tag, "_offer"}, spawn_valid, 1);
  endtask

  task automatic chk_fields(input string tag, input int lane, input int typ, input int spd);
    chk_eq({tag, "_lane"},  spawn_lane,  lane);
    chk_eq({tag, "_type"},  spawn_type,  typ);
    chk_eq({tag, "_speed"}, spawn_speed, spd);
  endtask

  task automatic accept_one();
    spawn_ready = 1'b1;
    cyc();
    spawn_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; frame_tick = 1'b0; rnd = 8'hA5;
    despawn = 1'b0; spawn_ready = 1'b0;
    cyc(); cyc();
    chk_eq("rst_valid", spawn_valid, 0);
    chk_eq("rst_count", active_count, 0);
    chk_fields("rst", 0, 0, 0);

    reset = 1'b1;
    cyc();
    chk_eq("idle_valid", spawn_valid, 0);

    // first spawn: gap 16+5=21, lane 1, type 2, speed 3
    enable = 1'b1;
    cyc();
    expire_gap(21, 8'hA5, "s1");
    chk_fields("s1", 1, 2, 3);
    chk_eq("s1_count_pre", active_count, 0);
    accept_one();
    chk_eq("s1_valid_drop", spawn_valid, 0);
    chk_eq("s1_count", active_count, 1);

    // same roll as last lane -> bumped to 2
    expire_gap(21, 8'hA5, "s2");
    chk_fields("s2", 2, 2, 3);
    accept_one();
    chk_eq("s2_count", active_count, 2);

    // accept with coincident despawn at count 2
    expire_gap(21, 8'hA5, "s3");
    chk_fields("s3", 1, 2, 3);
    spawn_ready = 1'b1; despawn = 1'b1;
    cyc();
    spawn_ready = 1'b0; despawn = 1'b0;
    chk_eq("s3_acc_desp_count", active_count, 2);

    // fill to MAX_ACTIVE; accept samples rnd=4E -> next gap 30
    expire_gap(21, 8'h4E, "s4");
    chk_fields("s4", 2, 1, 1);
    accept_one();
    chk_eq("s4_count", active_count, 3);

    // blocked in ROLL; extra ticks ignored
    run_ticks(30);
    chk_eq("blk_valid", spawn_valid, 0);
    run_ticks(3);
    chk_eq("blk_valid2", spawn_valid, 0);
    chk_eq("blk_count", active_count, 3);
    despawn = 1'b1;
    cyc();
    despawn = 1'b0;
    chk_eq("unblk_valid1", spawn_valid, 0);
    chk_eq("unblk_count", active_count, 2);
    cyc();
    chk_eq("unblk_valid2", spawn_valid, 1);
    chk_fields("unblk", 3, 1, 1);

    // back-pressure: fields stable while rnd churns
    for (int i = 0; i < 10; i++) begin
      rnd = 8'(i * 53 + 7);
      frame_tick = i[0];
      cyc();
      chk_eq("hold_valid", spawn_valid, 1);
      chk_fields("hold", 3, 1, 1);
    end
    frame_tick = 1'b0;
    rnd = 8'hF3;
    accept_one();
    chk_eq("hold_acc_valid", spawn_valid, 0);
    chk_eq("hold_acc_count", active_count, 3);
    cyc(); cyc(); cyc();
    chk_eq("once_count", active_count, 3);
    chk_eq("once_valid", spawn_valid, 0);

    despawn = 1'b1;
    cyc();
    despawn = 1'b0;
    chk_eq("desp_count", active_count, 2);

    // gap 16+3=19; lane 3 equals last lane -> wraps to 0
    expire_gap(19, 8'hC7, "wrap");
    chk_fields("wrap", 0, 3, 1);

    // disable during OFFER: withdrawn, fields and count kept
    enable = 1'b0;
    cyc();
    chk_eq("dis_valid", spawn_valid, 0);
    chk_eq("dis_count", active_count, 2);
    chk_fields("dis", 0, 3, 1);
    despawn = 1'b1;
    cyc();
    despawn = 1'b0;
    chk_eq("dis_desp_count", active_count, 1);
    chk_eq("dis_valid2", spawn_valid, 0);

    // re-enable reloads gap from current rnd: 16+2=18; last lane still 3
    rnd = 8'h02;
    enable = 1'b1;
    cyc();
    expire_gap(18, 8'h02, "reen");
    chk_fields("reen", 2, 0, 1);
    accept_one();
    chk_eq("reen_count", active_count, 2);

    despawn = 1'b1;
    cyc(); cyc();
    chk_eq("desp_to0", active_count, 0);
    cyc();
    despawn = 1'b0;
    chk_eq("desp_sat", active_count, 0);

    expire_gap(18, 8'h5B, "last");
    chk_fields("last", 3, 1, 2);

    // async reset mid-offer
    #2;
    reset = 1'b0;
    #1;
    chk_eq("areset_valid", spawn_valid, 0);
    chk_eq("areset_count", active_count, 0);
    chk_fields("areset", 0, 0, 0);
    reset = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
